gray_decoder: RTL
=================

Name: gray_decoder

Overview:
Receive side of the Gray-count path, recovering position from a Gray-coded bus.
- Takes an asynchronous WIDTH-bit Gray bus from another board, a header, or a gray_counter output.
- Synchronises the bus, converts it to binary and qualifies each transition as a legal single step.
- Reports the step direction and keeps a signed position count.
- Sits between external pins and sevenseg_decoder, or any consumer needing binary position.

Parameters:
- WIDTH, 4, Gray/binary word width.
- SYNC_STAGES, 2, synchroniser flop depth (min 2).
- POS_W, 16, width of the signed position accumulator.
- DEBOUNCE_CYCLES, 4, stability window; used only when GRAY_DEC_DEBOUNCE_EN is defined.

Ports:
- i_clk  input  1  system clock.
- i_rst  input  1  reset; synchronous and active-low; one clock.
- i_gray  input  WIDTH  asynchronous Gray-coded input.
- i_err_clr  input  1  clears the sticky error flag.
- o_bin  output  WIDTH  binary value of the last accepted Gray word.
- o_valid  output  1  one-cycle pulse per accepted legal step.
- o_dir  output  1  direction of the last legal step; 1 = up, 0 = down.
- o_pos  output  POS_W  signed step count, two's complement.
- o_err  output  1  sticky flag: an illegal multi-bit transition was seen.

Behaviour:
- Reset (i_rst=0 at a rising edge):
  - Synchroniser flops are cleared to 0.
  - o_bin=0, o_valid=0, o_dir=0, o_pos=0, o_err=0.
  - FSM goes to S_INIT.
  - Reset asserted mid-operation discards any pending sample.
- Synchroniser: i_gray passes through SYNC_STAGES flops, giving g_sync.
- Decode: bin = gray-to-binary of g_sync, computed as an XOR prefix from the MSB.
- FSM, S_INIT:
  - Waits SYNC_STAGES+1 cycles after reset release.
  - Then loads the reference word g_ref=g_sync and sets o_bin=bin(g_sync).
  - No o_valid pulse; o_pos unchanged.
  - Moves to S_TRACK.
- FSM, S_TRACK, each cycle compares g_sync with g_ref:
  - Equal: no action.
  - Hamming distance 1 (legal step):
    - o_bin <= bin(g_sync) and g_ref <= g_sync.
    - o_valid=1 for exactly one cycle.
    - o_dir = 1 if (bin_new - bin_old) mod 2^WIDTH == 1, else 0.
    - o_pos += 1 if up, else -1; o_pos wraps in two's complement with no saturation.
  - Hamming distance >1 (illegal):
    - o_err <= 1; no o_valid; o_pos unchanged.
    - Resync: g_ref <= g_sync and o_bin <= bin(g_sync).
    - Stays in S_TRACK.
- Wrap-around:
  - Binary max to 0, i.e. Gray 100..0 to 000..0, is a legal up step.
  - The reverse is a legal down step.
- Latency:
  - An input change at cycle N produces updated o_bin/o_valid on the edge ending cycle N+SYNC_STAGES+1.
  - That is 3 clocks with defaults.
- o_err:
  - Cleared by i_err_clr=1 at an edge.
  - If an error and i_err_clr coincide in the same cycle, the error wins and o_err stays 1.
- Back-to-back legal steps on consecutive cycles each produce their own o_valid pulse.
- All outputs are registered.

Optional Feature:
- GRAY_DEC_DEBOUNCE_EN defined:
  - A differing g_sync must remain identical for DEBOUNCE_CYCLES consecutive cycles before it is evaluated (legal or illegal).
  - Any change during the window restarts the counter.
  - A change back to g_ref during the window abandons the window.
  - Latency grows by DEBOUNCE_CYCLES.
- Not defined: evaluation happens immediately and the debounce counter is absent.

Decomposition:
- Package gray_pkg holds:
  - the state enum typedef (S_INIT, S_TRACK);
  - function gray2bin(WIDTH);
  - function popcount used for the Hamming check;
  - default constants WIDTH_DEF=4, SYNC_STAGES_DEF=2.
- Sub-module gray_sync: parameterised WIDTH x SYNC_STAGES flop chain with active-low synchronous reset to 0.

Test Plan (WIDTH=4, SYNC_STAGES=2, macro off unless stated):
- Reset: i_rst=0 with i_gray=0110 -> all outputs 0. Release -> after 3 clocks o_bin=4, o_valid never pulses, o_pos=0.
- Up step: 0110 -> 0111 -> 3 clocks later o_bin=5, o_valid high for 1 cycle, o_dir=1, o_pos=1. Then 0111 -> 0110 -> o_bin=4, o_dir=0, o_pos=0.
- Wrap: settle on 1000 (bin 15), then apply 0000 -> o_bin=0, o_dir=1, o_pos=+1. Then 0000 -> 1000 -> o_dir=0, o_pos back to 0.
- Illegal: 0000 -> 0011 -> o_err=1, no o_valid, o_bin=2, o_pos unchanged. i_err_clr=1 together with a second illegal jump -> o_err stays 1. Next i_err_clr alone -> o_err=0.
- Reset mid-operation: change i_gray, then assert i_rst 1 cycle later -> no o_valid, all outputs 0. After release, S_INIT re-captures the current input.
- GRAY_DEC_DEBOUNCE_EN, DEBOUNCE_CYCLES=4:
  - A 2-cycle glitch 0000 -> 0001 -> 0000 produces no o_valid and no o_err.
  - A 0001 held 6 cycles produces one o_valid at 3+4 clocks.

Source files
------------

// File: rtl/gray_pkg.sv
// Shared types and helpers for the Gray receive path: FSM states,
// Gray-to-binary conversion and the popcount behind the Hamming check.
package gray_pkg;

  typedef enum logic {S_INIT, S_TRACK} state_t;

  localparam int WIDTH_DEF       = 4;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int FN_W            = 32;

  // Operands are zero-extended, so the low bits of the result are exact for any narrower word.
  function automatic logic [FN_W-1:0] gray2bin(input logic [FN_W-1:0] g);
    logic [FN_W-1:0] b;
    b[FN_W-1] = g[FN_W-1];
    for (int i = FN_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [5:0] popcount(input logic [FN_W-1:0] v);
    logic [5:0] cnt;
    cnt = '0;
    for (int i = 0; i < FN_W; i++) begin
      cnt = cnt + 6'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/gray_sync.sv
// WIDTH x STAGES synchroniser chain with active-low synchronous clear.
module gray_sync #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] chain [STAGES];

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      for (int i = 0; i < STAGES; i++) begin
        chain[i] <= '0;
      end
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        chain[i] <= chain[i-1];
      end
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/gray_decoder.sv
// Gray bus receiver: synchronise, decode, qualify single-bit steps, track position.
// Optional debounce window enabled by defining GRAY_DEC_DEBOUNCE_EN.
//
// state   | meaning
// S_INIT  | waiting for the synchroniser to fill, then capture reference word
// S_TRACK | comparing each synchronised word against the reference
module gray_decoder
  import gray_pkg::*;
#(
  parameter int WIDTH           = WIDTH_DEF,
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int POS_W           = 16,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_gray,
  input  logic             i_err_clr,
  output logic [WIDTH-1:0] o_bin,
  output logic             o_valid,
  output logic             o_dir,
  output logic [POS_W-1:0] o_pos,
  output logic             o_err
);

  localparam int IW = $clog2(SYNC_STAGES + 1);

  if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1) begin : g_bad_param
    $error("gray_decoder: SYNC_STAGES must be >= 2 and DEBOUNCE_CYCLES >= 1");
  end

  state_t           state, state_nxt;
  logic [WIDTH-1:0] g_sync, g_ref, ref_nxt;
  logic [WIDTH-1:0] bin_sync, bin_nxt;
  logic [IW-1:0]    init_cnt, init_nxt;
  logic [5:0]       hd;
  logic             valid_nxt, dir_nxt, err_nxt, eval;
  logic [POS_W-1:0] pos_nxt;

`ifdef GRAY_DEC_DEBOUNCE_EN
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [WIDTH-1:0] cand, cand_nxt;
  logic [DW-1:0]    db_cnt, db_nxt;
  logic             armed, armed_nxt;
`endif

  gray_sync #(.WIDTH(WIDTH), .STAGES(SYNC_STAGES)) u_sync (
    .clk   (i_clk),
    .rst_b (i_rst),
    .d     (i_gray),
    .q     (g_sync)
  );

  assign bin_sync = WIDTH'(gray2bin(FN_W'(g_sync)));
  assign hd       = popcount(FN_W'(g_sync ^ g_ref));

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state    <= S_INIT;
      g_ref    <= '0;
      init_cnt <= IW'(SYNC_STAGES);
      o_bin    <= '0;
      o_valid  <= 1'b0;
      o_dir    <= 1'b0;
      o_pos    <= '0;
      o_err    <= 1'b0;
`ifdef GRAY_DEC_DEBOUNCE_EN
      cand     <= '0;
      db_cnt   <= '0;
      armed    <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      g_ref    <= ref_nxt;
      init_cnt <= init_nxt;
      o_bin    <= bin_nxt;
      o_valid  <= valid_nxt;
      o_dir    <= dir_nxt;
      o_pos    <= pos_nxt;
      o_err    <= err_nxt;
`ifdef GRAY_DEC_DEBOUNCE_EN
      cand     <= cand_nxt;
      db_cnt   <= db_nxt;
      armed    <= armed_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    ref_nxt   = g_ref;
    init_nxt  = init_cnt;
    bin_nxt   = o_bin;
    valid_nxt = 1'b0;
    dir_nxt   = o_dir;
    pos_nxt   = o_pos;
    err_nxt   = i_err_clr ? 1'b0 : o_err;
    eval      = 1'b0;
`ifdef GRAY_DEC_DEBOUNCE_EN
    cand_nxt  = cand;
    db_nxt    = db_cnt;
    armed_nxt = armed;
`endif
    case (state)
      S_INIT: begin
        if (init_cnt == '0) begin
          ref_nxt   = g_sync;
          bin_nxt   = bin_sync;
          state_nxt = S_TRACK;
        end else begin
          init_nxt = init_cnt - 1'b1;
        end
      end
      S_TRACK: begin
`ifdef GRAY_DEC_DEBOUNCE_EN
        // Down-counter starts on the first cycle a new candidate is seen.
        if (g_sync == g_ref) begin
          armed_nxt = 1'b0;
        end else if (!armed || g_sync != cand) begin
          cand_nxt  = g_sync;
          db_nxt    = DW'(DEBOUNCE_CYCLES - 1);
          armed_nxt = 1'b1;
        end else if (db_cnt == '0) begin
          eval      = 1'b1;
          armed_nxt = 1'b0;
        end else begin
          db_nxt = db_cnt - 1'b1;
        end
`else
        eval = (g_sync != g_ref);
`endif
        if (eval) begin
          ref_nxt = g_sync;
          bin_nxt = bin_sync;
          if (hd == 6'd1) begin
            valid_nxt = 1'b1;
            dir_nxt   = ((bin_sync - o_bin) == WIDTH'(1));
            pos_nxt   = dir_nxt ? o_pos + POS_W'(1) : o_pos - POS_W'(1);
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      default: state_nxt = S_INIT;
    endcase
  end

endmodule
